main_ctrl_fsm: RTL and testbench

Multicycle main control unit for the MIPS-subset datapath: a Moore state machine that sequences fetch, decode, execute, memory and write-back for each instruction. It sits directly upstream of the ALU control decoder, which consumes its 2-bit `alu_op` together with the instruction funct field. It also drives every datapath mux select and write enable. Memory accesses stall on a single-bit ready handshake.

---
 rtl/ctrl_pkg.sv | 62 ++++++
 rtl/ctrl_out_dec.sv | 75 +++++++
 rtl/main_ctrl_fsm.sv | 108 ++++++++++
 tb/tb_main_ctrl_fsm.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ctrl_pkg.sv
// Shared constants for the multicycle MIPS-subset main control unit:
// opcodes, the 4-bit state encoding, the alu_op / alu_src_b / pc_src codes
// and the packed bundle of datapath control signals.
package ctrl_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXEC   = 4'd6,
        S_ALUWB  = 4'd7,
        S_BRANCH = 4'd8,
        S_JUMP   = 4'd9,
        S_ADDIEX = 4'd10,
        S_ADDIWB = 4'd11
    } state_t;

    localparam logic [1:0] ALU_OP_ADD   = 2'b00;
    localparam logic [1:0] ALU_OP_SUB   = 2'b01;
    localparam logic [1:0] ALU_OP_FUNCT = 2'b10;

    localparam logic [1:0] ALU_B_REG     = 2'b00;
    localparam logic [1:0] ALU_B_FOUR    = 2'b01;
    localparam logic [1:0] ALU_B_IMM     = 2'b10;
    localparam logic [1:0] ALU_B_IMM_SH2 = 2'b11;

    localparam logic [1:0] PC_SRC_ALU    = 2'b00;
    localparam logic [1:0] PC_SRC_ALUOUT = 2'b01;
    localparam logic [1:0] PC_SRC_JUMP   = 2'b10;

    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic [1:0] pc_src;
        logic       i_or_d;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       mem_to_reg;
        logic       reg_dst;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
    } ctrl_t;

    function automatic logic is_supported(input logic [5:0] op);
        return (op == OP_RTYPE) || (op == OP_LW) || (op == OP_SW) ||
               (op == OP_BEQ)   || (op == OP_J)  || (op == OP_ADDI);
    endfunction

endpackage

// File: rtl/ctrl_out_dec.sv
// Combinational decode of the control-FSM state into datapath controls.
// Ports:
//   i_state     - current FSM state code (raw 4 bits; unused codes decode to all-zero)
//   i_mem_ready - memory handshake; only gates the FETCH-cycle IR/PC loads
//   o_ctrl      - bundle of every datapath mux select and write enable
module ctrl_out_dec
    import ctrl_pkg::*;
(
    input  logic [3:0] i_state,
    input  logic       i_mem_ready,
    output ctrl_t      o_ctrl
);

    always_comb begin
        o_ctrl = '0;
        case (i_state)
            S_FETCH: begin
                o_ctrl.mem_read  = 1'b1;
                o_ctrl.alu_src_b = ALU_B_FOUR;
                o_ctrl.alu_op    = ALU_OP_ADD;
                o_ctrl.pc_src    = PC_SRC_ALU;
                // PC+4 and the IR load commit only on the cycle the fetch completes
                o_ctrl.ir_write  = i_mem_ready;
                o_ctrl.pc_write  = i_mem_ready;
            end
            S_DECODE: begin
                // branch target precomputed into ALUOut ahead of BRANCH
                o_ctrl.alu_src_b = ALU_B_IMM_SH2;
                o_ctrl.alu_op    = ALU_OP_ADD;
            end
            S_MEMADR, S_ADDIEX: begin
                o_ctrl.alu_src_a = 1'b1;
                o_ctrl.alu_src_b = ALU_B_IMM;
                o_ctrl.alu_op    = ALU_OP_ADD;
            end
            S_MEMRD: begin
                o_ctrl.mem_read = 1'b1;
                o_ctrl.i_or_d   = 1'b1;
            end
            S_MEMWR: begin
                o_ctrl.mem_write = 1'b1;
                o_ctrl.i_or_d    = 1'b1;
            end
            S_MEMWB: begin
                o_ctrl.reg_write  = 1'b1;
                o_ctrl.mem_to_reg = 1'b1;
            end
            S_EXEC: begin
                o_ctrl.alu_src_a = 1'b1;
                o_ctrl.alu_src_b = ALU_B_REG;
                o_ctrl.alu_op    = ALU_OP_FUNCT;
            end
            S_ALUWB: begin
                o_ctrl.reg_write = 1'b1;
                o_ctrl.reg_dst   = 1'b1;
            end
            S_ADDIWB: begin
                o_ctrl.reg_write = 1'b1;
            end
            S_BRANCH: begin
                o_ctrl.alu_src_a     = 1'b1;
                o_ctrl.alu_src_b     = ALU_B_REG;
                o_ctrl.alu_op        = ALU_OP_SUB;
                o_ctrl.pc_write_cond = 1'b1;
                o_ctrl.pc_src        = PC_SRC_ALUOUT;
            end
            S_JUMP: begin
                o_ctrl.pc_write = 1'b1;
                o_ctrl.pc_src   = PC_SRC_JUMP;
            end
            default: o_ctrl = '0;
        endcase
    end

endmodule

// File: rtl/main_ctrl_fsm.sv
// Multicycle main control unit (Moore FSM) for the MIPS-subset datapath.
//
// state  | meaning
// -------+-----------------------------------------------
// FETCH  | read instruction at PC, PC+4, wait mem_ready
// DECODE | dispatch on opcode, precompute branch target
// MEMADR | compute load/store address
// MEMRD  | data read, wait mem_ready
// MEMWB  | write MDR to rt
// MEMWR  | data write, wait mem_ready
// EXEC   | R-type ALU operation
// ALUWB  | write ALUOut to rd
// BRANCH | beq compare and conditional PC load
// JUMP   | PC <= jump target
// ADDIEX | addi ALU operation
// ADDIWB | write ALUOut to rt
//
// Ports:
//   i_clk, i_rst (sync, active-high), i_opcode (instr[31:26]), i_mem_ready
//   o_* datapath controls, o_alu_op to the ALU control decoder,
//   o_illegal_op pulse in DECODE on unsupported opcode, o_state for debug.
//   Every output reads 0 while i_rst is high.
module main_ctrl_fsm
    import ctrl_pkg::*;
(
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic [5:0] i_opcode,
    input  logic       i_mem_ready,
    output logic       o_pc_write,
    output logic       o_pc_write_cond,
    output logic [1:0] o_pc_src,
    output logic       o_i_or_d,
    output logic       o_mem_read,
    output logic       o_mem_write,
    output logic       o_ir_write,
    output logic       o_mem_to_reg,
    output logic       o_reg_dst,
    output logic       o_reg_write,
    output logic       o_alu_src_a,
    output logic [1:0] o_alu_src_b,
    output logic [1:0] o_alu_op,
    output logic       o_illegal_op,
    output logic [3:0] o_state
);

    state_t r_state;
    ctrl_t  w_dec;
    ctrl_t  w_ctrl;
    logic   w_illegal;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= S_FETCH;
        end else begin
            case (r_state)
                S_FETCH:  if (i_mem_ready) r_state <= S_DECODE;
                S_DECODE: begin
                    case (i_opcode)
                        OP_LW, OP_SW: r_state <= S_MEMADR;
                        OP_RTYPE:     r_state <= S_EXEC;
                        OP_BEQ:       r_state <= S_BRANCH;
                        OP_J:         r_state <= S_JUMP;
                        OP_ADDI:      r_state <= S_ADDIEX;
                        default:      r_state <= S_FETCH;
                    endcase
                end
                S_MEMADR: begin
                    if (i_opcode == OP_SW)      r_state <= S_MEMWR;
                    else if (i_opcode == OP_LW) r_state <= S_MEMRD;
                    else                        r_state <= S_FETCH;
                end
                S_MEMRD:  if (i_mem_ready) r_state <= S_MEMWB;
                S_MEMWR:  if (i_mem_ready) r_state <= S_FETCH;
                S_EXEC:   r_state <= S_ALUWB;
                S_ADDIEX: r_state <= S_ADDIWB;
                default:  r_state <= S_FETCH;
            endcase
        end
    end

    ctrl_out_dec u_dec (
        .i_state     (r_state),
        .i_mem_ready (i_mem_ready),
        .o_ctrl      (w_dec)
    );

    // Reset blanks the outputs immediately so an in-flight write cannot complete.
    assign w_ctrl    = i_rst ? '0 : w_dec;
    assign w_illegal = !i_rst && (r_state == S_DECODE) && !is_supported(i_opcode);

    assign o_pc_write      = w_ctrl.pc_write;
    assign o_pc_write_cond = w_ctrl.pc_write_cond;
    assign o_pc_src        = w_ctrl.pc_src;
    assign o_i_or_d        = w_ctrl.i_or_d;
    assign o_mem_read      = w_ctrl.mem_read;
    assign o_mem_write     = w_ctrl.mem_write;
    assign o_ir_write      = w_ctrl.ir_write;
    assign o_mem_to_reg    = w_ctrl.mem_to_reg;
    assign o_reg_dst       = w_ctrl.reg_dst;
    assign o_reg_write     = w_ctrl.reg_write;
    assign o_alu_src_a     = w_ctrl.alu_src_a;
    assign o_alu_src_b     = w_ctrl.alu_src_b;
    assign o_alu_op        = w_ctrl.alu_op;
    assign o_illegal_op    = w_illegal;
    assign o_state         = i_rst ? 4'd0 : r_state;

endmodule

// File: tb/tb_main_ctrl_fsm.sv
module tb_main_ctrl_fsm;

    logic       i_clk = 1'b0;
    logic       i_rst = 1'b1;
    logic [5:0] i_opcode = 6'd0;
    logic       i_mem_ready = 1'b0;
    logic       o_pc_write, o_pc_write_cond, o_i_or_d, o_mem_read, o_mem_write;
    logic       o_ir_write, o_mem_to_reg, o_reg_dst, o_reg_write, o_alu_src_a, o_illegal_op;
    logic [1:0] o_pc_src, o_alu_src_b, o_alu_op;
    logic [3:0] o_state;

    localparam logic [5:0] LW = 6'b100011, SW = 6'b101011, RT = 6'b000000;
    localparam logic [5:0] BEQ = 6'b000100, JMP = 6'b000010, ADDI = 6'b001000, BAD = 6'b111111;

    typedef struct {
        logic       rst;
        logic       mr;
        logic [5:0] op;
    } stim_t;

    stim_t       stim_q[$];
    logic [21:0] exp_q[$];
    logic [21:0] w_obs;
    logic [21:0] e;
    int          n_checks = 0;
    int          n_fail = 0;

    main_ctrl_fsm dut (
        .i_clk           (i_clk),
        .i_rst           (i_rst),
        .i_opcode        (i_opcode),
        .i_mem_ready     (i_mem_ready),
        .o_pc_write      (o_pc_write),
        .o_pc_write_cond (o_pc_write_cond),
        .o_pc_src        (o_pc_src),
        .o_i_or_d        (o_i_or_d),
        .o_mem_read      (o_mem_read),
        .o_mem_write     (o_mem_write),
        .o_ir_write      (o_ir_write),
        .o_mem_to_reg    (o_mem_to_reg),
        .o_reg_dst       (o_reg_dst),
        .o_reg_write     (o_reg_write),
        .o_alu_src_a     (o_alu_src_a),
        .o_alu_src_b     (o_alu_src_b),
        .o_alu_op        (o_alu_op),
        .o_illegal_op    (o_illegal_op),
        .o_state         (o_state)
    );

    always #5 i_clk = ~i_clk;

    // {state, illegal, pc_write, pc_write_cond, pc_src, i_or_d, mem_read, mem_write,
    //  ir_write, mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op}
    assign w_obs = {o_state, o_illegal_op, o_pc_write, o_pc_write_cond, o_pc_src, o_i_or_d,
                    o_mem_read, o_mem_write, o_ir_write, o_mem_to_reg, o_reg_dst,
                    o_reg_write, o_alu_src_a, o_alu_src_b, o_alu_op};

    // Expected outputs written from the per-state output table.
    function automatic logic [21:0] exp_vec(input int st, input logic mr, input logic ill,
                                            input logic rst);
        logic pw = 0, pwc = 0, iod = 0, mrd = 0, mwr = 0, irw = 0, m2r = 0, rdst = 0, rw = 0, asa = 0;
        logic [1:0] psrc = 0, asb = 0, aop = 0;
        if (rst) return 22'd0;
        case (st)
            0:  begin mrd = 1; asb = 2'b01; irw = mr; pw = mr; end
            1:  asb = 2'b11;
            2, 10: begin asa = 1; asb = 2'b10; end
            3:  begin mrd = 1; iod = 1; end
            4:  begin rw = 1; m2r = 1; end
            5:  begin mwr = 1; iod = 1; end
            6:  begin asa = 1; aop = 2'b10; end
            7:  begin rw = 1; rdst = 1; end
            8:  begin asa = 1; aop = 2'b01; pwc = 1; psrc = 2'b01; end
            9:  begin pw = 1; psrc = 2'b10; end
            11: rw = 1;
            default: ;
        endcase
        return {4'(st), ill, pw, pwc, psrc, iod, mrd, mwr, irw, m2r, rdst, rw, asa, asb, aop};
    endfunction

    // Queue one cycle of stimulus with its expected result. Opcode is randomised
    // in every state where the FSM must ignore it.
    task automatic push(input int st, input logic mr, input logic [5:0] op,
                        input logic ill = 1'b0, input logic rst = 1'b0);
        stim_t s;
        s.rst = rst;
        s.mr  = mr;
        s.op  = op;
        if (!rst && st != 1 && st != 2) s.op = 6'($urandom_range(0, 63));
        stim_q.push_back(s);
        exp_q.push_back(exp_vec(st, mr, ill, rst));
    endtask

    task automatic apply_next();
        stim_t s;
        s = stim_q.pop_front();
        i_rst       = s.rst;
        i_mem_ready = s.mr;
        i_opcode    = s.op;
        @(negedge i_clk);
    endtask

    task automatic advance();
        @(posedge i_clk);
        #1;
    endtask

    task automatic test_reset();
        push(0, 1, LW, 0, 1);
        push(0, 0, SW, 0, 1);
        while (exp_q.size() > 0) begin
            apply_next();
            e = exp_q.pop_front();
            n_checks++;
            if (w_obs !== e) begin
                n_fail++;
                $display("FAIL reset: got %h expected %h", w_obs, e);
            end
            advance();
        end
    endtask

    task automatic test_lw();
        for (int s = 0; s <= 4; s++) push(s, 1, LW);
        while (exp_q.size() > 0) begin
            apply_next();
            e = exp_q.pop_front();
            n_checks++;
            if (w_obs !== e) begin
                n_fail++;
                $display("FAIL lw: got %h expected %h", w_obs, e);
            end
            advance();
        end
    endtask

    task automatic test_rtype();
        push(0, 1, RT); push(1, 1, RT); push(6, 1, RT); push(7, 1, RT);
        while (exp_q.size() > 0) begin
            apply_next();
            e = exp_q.pop_front();
            n_checks++;
            if (w_obs !== e) begin
                n_fail++;
                $display("FAIL rtype: got %h expected %h", w_obs, e);
            end
            advance();
        end
    endtask

    task automatic test_sw_stall();
        push(0, 1, SW); push(1, 1, SW); push(2, 1, SW);
        push(5, 0, SW); push(5, 0, SW); push(5, 0, SW); push(5, 1, SW);
        while (exp_q.size() > 0) begin
            apply_next();
            e = exp_q.pop_front();
            n_checks++;
            if (w_obs !== e) begin
                n_fail++;
                $display("FAIL sw_stall: got %h expected %h", w_obs, e);
            end
            advance();
        end
    endtask

    task automatic test_beq_j();
        push(0, 1, BEQ); push(1, 1, BEQ); push(8, 1, BEQ);
        push(0, 1, JMP); push(1, 1, JMP); push(9, 1, JMP);
        while (exp_q.size() > 0) begin
            apply_next();
            e = exp_q.pop_front();
            n_checks++;
            if (w_obs !== e) begin
                n_fail++;
                $display("FAIL beq_j: got %h expected %h", w_obs, e);
            end
            advance();
        end
    endtask

    task automatic test_addi_fetch_stall();
        push(0, 0, ADDI); push(0, 0, ADDI); push(0, 1, ADDI);
        push(1, 1, ADDI); push(10, 1, ADDI); push(11, 1, ADDI);
        while (exp_q.size() > 0) begin
            apply_next();
            e = exp_q.pop_front();
            n_checks++;
            if (w_obs !== e) begin
                n_fail++;
                $display("FAIL addi_fetch_stall: got %h expected %h", w_obs, e);
            end
            advance();
        end
    endtask

    task automatic test_back_to_back_illegal();
        push(0, 1, BAD); push(1, 1, BAD, 1);
        push(0, 1, BAD); push(1, 1, 6'b000001, 1);
        push(0, 1, LW); push(1, 1, LW); push(2, 1, LW); push(3, 1, LW); push(4, 1, LW);
        while (exp_q.size() > 0) begin
            apply_next();
            e = exp_q.pop_front();
            n_checks++;
            if (w_obs !== e) begin
                n_fail++;
                $display("FAIL back_to_back_illegal: got %h expected %h", w_obs, e);
            end
            advance();
        end
    endtask

    task automatic test_reset_in_stall();
        push(0, 1, LW); push(1, 1, LW); push(2, 1, LW);
        push(3, 0, LW); push(3, 0, LW);
        push(0, 1, LW, 0, 1); push(0, 0, LW, 0, 1);
        push(0, 1, JMP); push(1, 1, JMP); push(9, 1, JMP); push(0, 0, JMP);
        while (exp_q.size() > 0) begin
            apply_next();
            e = exp_q.pop_front();
            n_checks++;
            if (w_obs !== e) begin
                n_fail++;
                $display("FAIL reset_in_stall: got %h expected %h", w_obs, e);
            end
            advance();
        end
    endtask

    initial begin
        test_reset();
        test_lw();
        test_rtype();
        test_sw_stall();
        test_beq_j();
        test_addi_fetch_stall();
        test_back_to_back_illegal();
        test_reset_in_stall();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
